// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-requester front end for the shared 4-bit ALU
// Optional completed-operation counter enabled by defining ALU_ARB_OPCOUNT_EN.
module alu_arbiter #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
`ifdef ALU_ARB_OPCOUNT_EN
  ,
  output logic [CNT_W-1:0]  op_count
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q;
  logic              last_grant_q;
  logic              owner_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp0_result_q, rsp1_result_q;
  logic              rsp0_zero_q, rsp1_zero_q;

  logic grant;
  logic accept;
  logic own_rsp_ready;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end
    accept        = (state_q == IDLE) && (req0_valid || req1_valid);
    own_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
  end

  assign req0_ready  = accept && !grant;
  assign req1_ready  = accept && grant;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_op_q;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_zero   = rsp1_zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      rsp_valid_q   <= '0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a_q      <= grant ? req1_a  : req0_a;
            alu_b_q      <= grant ? req1_b  : req0_b;
            alu_op_q     <= grant ? req1_op : req0_op;
            owner_q      <= grant;
            last_grant_q <= grant;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (owner_q) begin
            rsp1_result_q <= alu_result;
            rsp1_zero_q   <= alu_zero;
          end else begin
            rsp0_result_q <= alu_result;
            rsp0_zero_q   <= alu_zero;
          end
          rsp_valid_q[owner_q] <= 1'b1;
          state_q              <= RESP;
        end
        RESP: begin
          if (own_rsp_ready) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_OPCOUNT_EN
  logic [CNT_W-1:0] op_count_q;

  // Saturating count of completed response handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (state_q == RESP && own_rsp_ready && op_count_q != {CNT_W{1'b1}}) begin
      op_count_q <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign op_count = op_count_q;
`endif

endmodule
